axi_lite_master_arbiter: RTL and testbench

Two-requester AXI4-Lite master that shares one AXI4-Lite slave register bank between two local agents. Each requester issues single read or write commands over a simple valid/done interface. The block arbitrates, latches the winning command, and sequences the AW/W/B or AR/R channel handshakes with one transaction outstanding. It returns read data and the response code to the winner, then re-arbitrates.

---
 rtl/axi_lite_master_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_master_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_arbiter.sv
// Two-requester AXI4-Lite master, one transaction outstanding.
// Define AXI_LITE_ARB_RR_EN for round-robin arbitration (else REQ0 priority).
module axi_lite_master_arbiter #(
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            REQ0_VALID,
  input  logic                            REQ0_WE,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   REQ0_WDATA,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0] REQ0_WSTRB,
  output logic                            REQ0_DONE,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   REQ0_RDATA,
  output logic [1:0]                      REQ0_RESP,
  input  logic                            REQ1_VALID,
  input  logic                            REQ1_WE,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   REQ1_WDATA,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0] REQ1_WSTRB,
  output logic                            REQ1_DONE,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   REQ1_RDATA,
  output logic [1:0]                      REQ1_RESP,
  output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [P_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = P_M_AXI_DATA_WIDTH;
  localparam int AW = P_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA, FIN
  } state_t;

  state_t        state;
  logic          gnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic          any_req;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;
  logic          aw_ok;
  logic          w_ok;

  assign any_req = REQ0_VALID | REQ1_VALID;

`ifdef AXI_LITE_ARB_RR_EN
  logic last;

  assign pick = (REQ0_VALID && REQ1_VALID) ? ~last : REQ1_VALID;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)
      last <= 1'b1;
    else if (state == IDLE && any_req)
      last <= pick;
  end
`else
  assign pick = ~REQ0_VALID;
`endif

  always_comb begin
    sel_we    = REQ0_WE;
    sel_addr  = REQ0_ADDR;
    sel_wdata = REQ0_WDATA;
    sel_wstrb = REQ0_WSTRB;
    if (pick) begin
      sel_we    = REQ1_WE;
      sel_addr  = REQ1_ADDR;
      sel_wdata = REQ1_WDATA;
      sel_wstrb = REQ1_WSTRB;
    end
  end

  // A channel is finished once its VALID has dropped or is being accepted now.
  assign aw_ok = ~M_AXI_AWVALID | M_AXI_AWREADY;
  assign w_ok  = ~M_AXI_WVALID  | M_AXI_WREADY;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      REQ0_DONE     <= 1'b0;
      REQ1_DONE     <= 1'b0;
      REQ0_RDATA    <= '0;
      REQ1_RDATA    <= '0;
      REQ0_RESP     <= 2'b00;
      REQ1_RESP     <= 2'b00;
    end else begin
      REQ0_DONE <= 1'b0;
      REQ1_DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            if (sel_we) begin
              state         <= WADDR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end else begin
              state         <= RADDR;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (M_AXI_AWREADY)
            M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)
            M_AXI_WVALID <= 1'b0;
          if (aw_ok && w_ok) begin
            state        <= WRESP;
            M_AXI_BREADY <= 1'b1;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID) begin
            state        <= FIN;
            M_AXI_BREADY <= 1'b0;
            if (gnt) begin
              REQ1_RESP <= M_AXI_BRESP;
              REQ1_DONE <= 1'b1;
            end else begin
              REQ0_RESP <= M_AXI_BRESP;
              REQ0_DONE <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (M_AXI_ARREADY) begin
            state         <= RDATA;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            state        <= FIN;
            M_AXI_RREADY <= 1'b0;
            if (gnt) begin
              REQ1_RDATA <= M_AXI_RDATA;
              REQ1_RESP  <= M_AXI_RRESP;
              REQ1_DONE  <= 1'b1;
            end else begin
              REQ0_RDATA <= M_AXI_RDATA;
              REQ0_RESP  <= M_AXI_RRESP;
              REQ0_DONE  <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter.
// Slave responses are hand-driven cycle by cycle.
module tb_axi_lite_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_we, r0_done;
  logic [3:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic [3:0]  r0_wstrb;
  logic [1:0]  r0_resp;
  logic        r1_valid, r1_we, r1_done;
  logic [3:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic [3:0]  r1_wstrb;
  logic [1:0]  r1_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;
  int aw_hs  = 0;
  int w_hs   = 0;

  always #5 clk = ~clk;

  axi_lite_master_arbiter dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .REQ0_VALID    (r0_valid),
    .REQ0_WE       (r0_we),
    .REQ0_ADDR     (r0_addr),
    .REQ0_WDATA    (r0_wdata),
    .REQ0_WSTRB    (r0_wstrb),
    .REQ0_DONE     (r0_done),
    .REQ0_RDATA    (r0_rdata),
    .REQ0_RESP     (r0_resp),
    .REQ1_VALID    (r1_valid),
    .REQ1_WE       (r1_we),
    .REQ1_ADDR     (r1_addr),
    .REQ1_WDATA    (r1_wdata),
    .REQ1_WSTRB    (r1_wstrb),
    .REQ1_DONE     (r1_done),
    .REQ1_RDATA    (r1_rdata),
    .REQ1_RESP     (r1_resp),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       w;
    logic [3:0] ea;
    rst = 1'b1;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_wstrb = 0;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_wstrb = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    tick;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_done0", r0_done, 0);
    chk("rst_prot", {awprot, arprot}, 0);
    rst = 0;
    awready = 1; wready = 1; arready = 1;

    // REQ0 write, zero-wait slave
    r0_valid = 1; r0_we = 1; r0_addr = 4'h1;
    r0_wdata = 32'hDEADBEEF; r0_wstrb = 4'hF;
    tick;
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid", wvalid, 1);
    chk("w1_awaddr", awaddr, 4'h1);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", wstrb, 4'hF);
    tick;
    chk("w1_valids_low", {awvalid, wvalid}, 0);
    chk("w1_bready", bready, 1);
    bvalid = 1; bresp = 2'b00;
    tick;
    chk("w1_done0", r0_done, 1);
    chk("w1_done1", r1_done, 0);
    chk("w1_resp0", r0_resp, 2'b00);
    chk("w1_bready_low", bready, 0);
    bvalid = 0; r0_valid = 0;
    tick;
    chk("w1_done_pulse", r0_done, 0);

    // REQ1 read back
    r1_valid = 1; r1_we = 0; r1_addr = 4'h1;
    tick;
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 4'h1);
    tick;
    chk("r1_arvalid_low", arvalid, 0);
    chk("r1_rready", rready, 1);
    rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick;
    chk("r1_done1", r1_done, 1);
    chk("r1_done0", r0_done, 0);
    chk("r1_rdata1", r1_rdata, 32'hDEADBEEF);
    chk("r1_resp1", r1_resp, 2'b00);
    rvalid = 0; r1_valid = 0;
    tick;
    chk("r1_done_pulse", r1_done, 0);
    chk("r1_rdata_held", r1_rdata, 32'hDEADBEEF);

    // REQ1 write with AWREADY held low for 3 cycles
    awready = 0;
    r1_valid = 1; r1_we = 1; r1_addr = 4'h2;
    r1_wdata = 32'h12345678; r1_wstrb = 4'h3;
    tick;
    chk("w3_valids", {awvalid, wvalid}, 2'b11);
    chk("w3_wstrb", wstrb, 4'h3);
    tick;
    chk("w3_c2", {awvalid, wvalid, bready}, 3'b100);
    tick;
    chk("w3_c3", {awvalid, wvalid, bready}, 3'b100);
    awready = 1;
    tick;
    chk("w3_c4", {awvalid, wvalid, bready}, 3'b001);
    tick;
    chk("w3_wait_b", {bready, r1_done}, 2'b10);
    bvalid = 1; bresp = 2'b00;
    tick;
    chk("w3_done1", r1_done, 1);
    chk("w3_aw_hs", aw_hs, 2);
    chk("w3_w_hs", w_hs, 2);
    bvalid = 0; r1_valid = 0;
    tick;
    chk("w3_done_pulse", r1_done, 0);

    // Both requesters held: REQ0 reads 3, REQ1 reads 5
    r0_we = 0; r0_addr = 4'h3;
    r1_we = 0; r1_addr = 4'h5;
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_LITE_ARB_RR_EN
      w = i[0];
`else
      w = (i >= 2);
`endif
      ea = w ? 4'h5 : 4'h3;
      tick;
      chk("arb_araddr", araddr, ea);
      tick;
      rvalid = 1; rdata = 32'hA0 + i; rresp = 2'b00;
      tick;
      chk("arb_done", {r1_done, r0_done}, w ? 2'b10 : 2'b01);
      chk("arb_rdata", w ? r1_rdata : r0_rdata, 32'hA0 + i);
      rvalid = 0;
      if (w) r1_valid = 0;
      else   r0_valid = 0;
      tick;
      if (i < 3) begin
        r1_valid = 1;
`ifdef AXI_LITE_ARB_RR_EN
        r0_valid = 1;
`else
        r0_valid = (i == 0);
`endif
      end
    end
    r0_valid = 0; r1_valid = 0;

    // Error response passed through
    r0_valid = 1; r0_we = 0; r0_addr = 4'h7;
    tick;
    tick;
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
    tick;
    chk("err_done0", r0_done, 1);
    chk("err_resp0", r0_resp, 2'b10);
    chk("err_rdata0", r0_rdata, 32'hCAFEF00D);
    rvalid = 0; r0_valid = 0;
    tick;
    chk("err_idle", {r0_done, arvalid, rready}, 0);

    // Reset while waiting for BVALID
    r0_valid = 1; r0_we = 1; r0_addr = 4'h9;
    r0_wdata = 32'h55AA55AA; r0_wstrb = 4'hC;
    tick;
    tick;
    chk("rst_in_wresp", bready, 1);
    rst = 1; bvalid = 1;
    #1;
    chk("arst_ready", {bready, awvalid, wvalid, arvalid, rready}, 0);
    chk("arst_addr", {awaddr, araddr, wstrb}, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_rdata", {r0_rdata, r1_rdata}, 0);
    chk("arst_resp", {r0_resp, r1_resp}, 0);
    tick;
    chk("arst_no_done", {r0_done, r1_done}, 0);
    rst = 0; bvalid = 0;
    r0_addr = 4'hA; r0_wdata = 32'h0BADF00D; r0_wstrb = 4'hF;
    tick;
    chk("post_awvalid", {awvalid, wvalid}, 2'b11);
    chk("post_awaddr", awaddr, 4'hA);
    chk("post_wdata", wdata, 32'h0BADF00D);
    tick;
    chk("post_bready", bready, 1);
    bvalid = 1; bresp = 2'b00;
    tick;
    chk("post_done0", r0_done, 1);
    chk("post_resp0", r0_resp, 2'b00);
    bvalid = 0; r0_valid = 0;
    tick;
    chk("post_done_pulse", r0_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
